// File: rtl/mat_stream_driver.sv
// Byte-stream front end for the 2x2 matmul core: assembles A/B from a valid/ready
// byte stream, waits the core latency, captures C and streams it back out.
module mat_stream_driver #(
    parameter int unsigned MAT_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] C,
    output logic        busy,
    output logic [15:0] op_count
);
    localparam int unsigned LAT_W = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        SEND
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [31:0]        result;
    logic [4:0]         cur_base;
    logic [4:0]         nxt_base;

    // Bit offsets of the current and following byte lanes
    assign idx_nxt  = idx + IDX_W'(1);
    assign cur_base = {idx, 3'b000};
    assign nxt_base = {idx_nxt, 3'b000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            lat_cnt  <= '0;
            result   <= '0;
            A        <= '0;
            B        <= '0;
            op_count <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= LOAD_A;
                    idx     <= '0;
                    s_ready <= 1'b1;
                end
                LOAD_A: begin
                    if (s_valid && s_ready) begin
                        A[cur_base +: 8] <= s_data;
                        idx              <= idx_nxt;
                        if (idx == IDX_W'(3)) begin
                            state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (s_valid && s_ready) begin
                        B[cur_base +: 8] <= s_data;
                        idx              <= idx_nxt;
                        if (idx == IDX_W'(3)) begin
                            state   <= WAIT;
                            lat_cnt <= LAT_W'(MAT_LATENCY);
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Capture C on the edge that ends the last latency cycle
                    if (lat_cnt == '0) begin
                        result  <= C;
                        state   <= SEND;
                        m_valid <= 1'b1;
                        m_data  <= C[7:0];
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        idx <= idx_nxt;
                        if (idx == IDX_W'(3)) begin
                            op_count <= op_count + 16'd1;
                            state    <= LOAD_A;
                            m_valid  <= 1'b0;
                            m_data   <= '0;
                            s_ready  <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            m_data <= result[nxt_base +: 8];
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_driver.sv
// Bench for mat_stream_driver: two instances (latency 2 and 0) fed by directed and
// random byte streams, with a behavioural 2x2 matmul core and expected-result model.
module tb_mat_stream_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  s_data   [2];
    logic        s_valid  [2];
    logic        s_ready  [2];
    logic [7:0]  m_data   [2];
    logic        m_valid  [2];
    logic        m_ready  [2];
    logic [31:0] a_bus    [2];
    logic [31:0] b_bus    [2];
    logic [31:0] c_bus    [2];
    logic        busy     [2];
    logic [15:0] op_count [2];

    int errors = 0;
    int checks = 0;
    int exp_ops [2];
    logic stub_mode = 1'b0;
    int unsigned cyc [2];

    always #5 clk = ~clk;

    mat_stream_driver #(.MAT_LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .A(a_bus[0]), .B(b_bus[0]), .C(c_bus[0]),
        .busy(busy[0]), .op_count(op_count[0])
    );

    mat_stream_driver #(.MAT_LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .A(a_bus[1]), .B(b_bus[1]), .C(c_bus[1]),
        .busy(busy[1]), .op_count(op_count[1])
    );

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Row-major 2x2 product, each element truncated to 8 bits
    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        int unsigned am [2][2];
        int unsigned bm [2][2];
        logic [31:0] c;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                am[i][j] = 32'(a[8*(2*i+j) +: 8]);
                bm[i][j] = 32'(b[8*(2*i+j) +: 8]);
            end
        end
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c[8*(2*i+j) +: 8] = 8'(am[i][0]*bm[0][j] + am[i][1]*bm[1][j]);
            end
        end
        return c;
    endfunction

    // cyc[d] == n during cycle t+n of a busy period
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) cyc[d] <= busy[d] ? cyc[d] + 1 : 0;
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            c_bus[d] = stub_mode ? ((cyc[d] == lat_of(d)) ? 32'h04030201 : 32'hDEADBEEF)
                                 : matmul(a_bus[d], b_bus[d]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int gap, output int stall);
        s_valid[d] = 1'b0;
        repeat (gap) begin
            s_data[d] = 8'($urandom);
            @(negedge clk);
        end
        s_valid[d] = 1'b1;
        s_data[d]  = b;
        stall = 0;
        while (s_ready[d] !== 1'b1 && stall < 50) begin
            @(negedge clk);
            stall++;
        end
        chk("s_ready_timeout", 32'(stall < 50), 1);
        @(negedge clk);
        s_valid[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic [63:0] stream, input int gap, input int hold_j,
                          input logic [31:0] exp_c, input int n_out, output int first_stall);
        int stall;
        int w;
        logic [7:0] held;
        first_stall = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(d, stream[8*i +: 8], gap, stall);
            if (i == 0) first_stall = stall;
        end
        chk("A_loaded", a_bus[d], stream[31:0]);
        chk("B_loaded", b_bus[d], stream[63:32]);
        chk("busy_wait", 32'(busy[d]), 1);
        chk("s_ready_wait", 32'(s_ready[d]), 0);
        w = 0;
        while (m_valid[d] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("wait_cycles", w, lat_of(d) + 1);
        for (int j = 0; j < n_out; j++) begin
            m_ready[d] = 1'b0;
            if (j == hold_j) begin
                held = m_data[d];
                repeat (5) begin
                    chk("hold_valid", 32'(m_valid[d]), 1);
                    chk("hold_data", 32'(m_data[d]), 32'(held));
                    chk("hold_s_ready", 32'(s_ready[d]), 0);
                    chk("hold_busy", 32'(busy[d]), 1);
                    @(negedge clk);
                end
            end
            chk("m_valid", 32'(m_valid[d]), 1);
            chk("m_data", 32'(m_data[d]), 32'(exp_c[8*j +: 8]));
            m_ready[d] = 1'b1;
            @(negedge clk);
        end
        m_ready[d] = 1'b0;
        if (n_out == 4) begin
            exp_ops[d] = (exp_ops[d] + 1) % 65536;
            chk("end_m_valid", 32'(m_valid[d]), 0);
            chk("end_m_data", 32'(m_data[d]), 0);
            chk("end_s_ready", 32'(s_ready[d]), 1);
            chk("end_busy", 32'(busy[d]), 0);
            chk("op_count", 32'(op_count[d]), 32'(exp_ops[d]));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) begin
            for (int d = 0; d < 2; d++) begin
                s_data[d]  = 8'($urandom);
                s_valid[d] = 1'($urandom);
                m_ready[d] = 1'($urandom);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_s_ready", 32'(s_ready[d]), 0);
                chk("rst_m_valid", 32'(m_valid[d]), 0);
                chk("rst_m_data", 32'(m_data[d]), 0);
                chk("rst_A", a_bus[d], 0);
                chk("rst_B", b_bus[d], 0);
                chk("rst_op_count", 32'(op_count[d]), 0);
                chk("rst_busy", 32'(busy[d]), 0);
            end
        end
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            m_ready[d] = 1'b0;
            exp_ops[d] = 0;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("rel_cycle1_s_ready", 32'(s_ready[d]), 0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("rel_cycle2_s_ready", 32'(s_ready[d]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs;
        int d;
        logic [63:0] st;
        for (int i = 0; i < 2; i++) begin
            s_data[i]  = '0;
            s_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
            exp_ops[i] = 0;
        end

        apply_reset();

        // Identity A times B, with an idle cycle before every input byte
        st = {32'h08070605, 32'h01000001};
        run_op(0, st, 1, -1, 32'h08070605, 4, fs);

        // Backpressure on result byte 1
        st = {32'($urandom), 32'($urandom)};
        run_op(0, st, 0, 1, matmul(st[31:0], st[63:32]), 4, fs);

        // Random operations on both latencies
        for (int k = 0; k < 6; k++) begin
            d  = k % 2;
            st = {32'($urandom), 32'($urandom)};
            run_op(d, st, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                   matmul(st[31:0], st[63:32]), 4, fs);
        end

        // Latency alignment: C is correct only in cycle t+MAT_LATENCY
        stub_mode = 1'b1;
        run_op(0, {32'($urandom), 32'($urandom)}, 0, -1, 32'h04030201, 4, fs);
        run_op(1, {32'($urandom), 32'($urandom)}, 0, -1, 32'h04030201, 4, fs);
        stub_mode = 1'b0;

        // Reset after two of four result bytes
        st = {32'($urandom), 32'($urandom)};
        run_op(0, st, 0, -1, matmul(st[31:0], st[63:32]), 2, fs);
        #2 rst = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid[0]), 0);
        chk("midrst_m_data", 32'(m_data[0]), 0);
        chk("midrst_op_count", 32'(op_count[0]), 0);
        chk("midrst_busy", 32'(busy[0]), 0);
        chk("midrst_A", a_bus[0], 0);
        apply_reset();

        // Back-to-back operations with m_ready held high
        st = {32'($urandom), 32'($urandom)};
        run_op(0, st, 0, -1, matmul(st[31:0], st[63:32]), 4, fs);
        st = {32'h10101010, 32'h10101010};
        run_op(0, st, 0, -1, 32'h00000000, 4, fs);
        chk("b2b_first_stall", fs, 0);
        chk("b2b_op_count", 32'(op_count[0]), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
